if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction fetch stage: owns the PC, issues in-order fetches to instruction memory,
//   buffers returned words in a small prefetch FIFO and drives the IF/ID pipeline register
//   that feeds id_stage. Honours the ID stall (id_stall_flag) and EX redirects
//   (taken branch / JAL / JALR), squashing stale fetches.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   FBUF_DEPTH  2              prefetch FIFO entries; power of 2, >=2
//   NOP_INST    32'h0000_0013  word driven on if_id_IR when the slot is a bubble (addi x0,x0,0)
// PORTS
//   clk               in   1   system clock
//   rst               in   1   asynchronous reset, active-high
//   id_stall_flag     in   1   ID hazard stall: hold IF/ID register
//   ex_take_branch    in   1   redirect fetch to ex_target_pc
//   ex_target_pc      in   32  redirect target; bits [1:0] ignored (forced 0)
//   imem_req          out  1   fetch request, single-cycle pulse
//   imem_addr         out  32  fetch address; valid while imem_req=1
//   imem_rvalid       in   1   fetch response valid, >=1 cycle after request, in order
//   imem_rdata        in   32  fetched instruction word
//   if_id_IR          out  32  instruction to ID
//   if_id_PC          out  32  PC of if_id_IR
//   if_id_NPC         out  32  if_id_PC + 4
//   if_id_valid_inst  out  1   IF/ID slot holds a real instruction
//   if_fetch_count    out  32  count of valid instructions loaded into IF/ID (wraps)
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, FIFO empty, FSM=IDLE, imem_req=0, imem_addr=0,
//     if_id_IR=NOP_INST, if_id_PC=0, if_id_NPC=4, if_id_valid_inst=0, if_fetch_count=0.
//   FSM, at most one outstanding request:
//     IDLE : if (fifo_count < FBUF_DEPTH) && !ex_take_branch -> imem_req=1, imem_addr=pc,
//            pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT; else stay.
//     WAIT : imem_rvalid -> push {pc_of_req, imem_rdata}, go IDLE (next request earliest
//            the following cycle). ex_take_branch w/o rvalid -> DRAIN.
//            ex_take_branch with rvalid same cycle -> discard word, go IDLE.
//     DRAIN: discard the next imem_rvalid word, go IDLE; further redirects stay in DRAIN.
//   imem_rvalid in IDLE is ignored (covers responses to requests issued before reset).
//   Request issue counts the in-flight slot, so a push never finds the FIFO full.
//   IF/ID load, each cycle, priority order:
//     1 ex_take_branch: pc<=ex_target_pc&~3, FIFO flushed, IF/ID <= bubble
//       (valid=0, IR=NOP_INST); overrides id_stall_flag.
//     2 id_stall_flag: IF/ID holds all fields; FIFO may still fill.
//     3 FIFO non-empty: pop head into IF/ID, valid=1, NPC=PC+4, if_fetch_count+=1.
//     4 otherwise: IF/ID <= bubble (valid=0, IR=NOP_INST, PC/NPC hold).
//   Simultaneous push+pop allowed in one cycle; count unchanged.
//   Latency (no bypass): request at cycle t, rvalid at t+L -> IF/ID valid in t+L+2.
//   Steady-state throughput with L=1: one instruction per 2 cycles (single outstanding).
// CONFIGURATION
//   FETCH_BYPASS_EN defined: if FIFO empty, no stall, no redirect and the response is
//     accepted that cycle, imem_rdata is loaded directly into IF/ID (FIFO not written);
//     IF/ID valid in t+L+1.
//   Undefined: every response goes through the FIFO; latency as above.
// TESTING
//   Reset, L=1, no stall: first imem_addr=RESET_PC; IF/ID shows PC 0,4,8 with
//     if_id_NPC=PC+4; first valid 3 cycles after request (2 with FETCH_BYPASS_EN).
//   id_stall_flag high 5 cycles: IF/ID frozen at one PC, FIFO reaches FBUF_DEPTH,
//     imem_req stops; release -> buffered PCs appear back-to-back, none lost or repeated.
//   ex_take_branch=1, target=32'h0000_0103 while WAIT, rvalid 2 cycles later: stale word
//     dropped, next imem_addr=32'h0000_0100, IF/ID bubble in the redirect cycle.
//   Redirect same cycle as rvalid and id_stall_flag: word dropped, IF/ID bubble, no DRAIN.
//   pc=32'hFFFF_FFFC fetch: next imem_addr=0; if_fetch_count increments per valid load only.
//   Assert rst while WAIT, response arrives after release: ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem fetch FSM, prefetch FIFO and IF/ID register.
// Optional FETCH_BYPASS_EN: a response arriving with the FIFO empty and ID ready goes straight into IF/ID.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FBUF_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stall_flag,
   input  logic        ex_take_branch,
   input  logic [31:0] ex_target_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_IR,
   output logic [31:0] if_id_PC,
   output logic [31:0] if_id_NPC,
   output logic        if_id_valid_inst,
   output logic [31:0] if_fetch_count
);

   localparam int PTR_W = $clog2(FBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN
   } fetch_state_t;

   fetch_state_t state, state_next;

   logic [31:0]      pc;
   logic [31:0]      req_pc;
   logic [31:0]      target_aligned;
   logic [31:0]      fifo_pc [FBUF_DEPTH];
   logic [31:0]      fifo_ir [FBUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic             accept;
   logic             bypass_load;
   logic             issue;

   // Rspons accepted only for a live (non-squashed) request; a redirect in the same cycle drops it.
   always_comb begin
      target_aligned = ex_target_pc & 32'hFFFF_FFFC;
      fifo_empty     = (fifo_count == '0);
      fifo_pop       = !ex_take_branch && !id_stall_flag && !fifo_empty;
      accept         = (state == WAIT) && imem_rvalid && !ex_take_branch;
`ifdef FETCH_BYPASS_EN
      bypass_load    = accept && fifo_empty && !id_stall_flag;
`else
      bypass_load    = 1'b0;
`endif
      fifo_push      = accept && !bypass_load;
      issue          = (state == IDLE) && !rst && !ex_take_branch &&
                       (fifo_count < CNT_W'(FBUF_DEPTH));
   end

   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      imem_addr  = '0;
      case (state)
         IDLE: begin
            if (issue) begin
               imem_req   = 1'b1;
               imem_addr  = pc;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_next = IDLE;
            end else if (ex_take_branch) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (imem_rvalid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         req_pc <= '0;
      end else if (ex_take_branch) begin
         pc <= target_aligned;
      end else if (issue) begin
         pc     <= pc + 32'd4;
         req_pc <= pc;
      end
   end

   // Pointers wrap naturally because FBUF_DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else if (ex_take_branch) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_pc[wr_ptr] <= req_pc;
         fifo_ir[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_IR         <= NOP_INST;
         if_id_PC         <= '0;
         if_id_NPC        <= 32'd4;
         if_id_valid_inst <= 1'b0;
         if_fetch_count   <= '0;
      end else if (ex_take_branch) begin
         if_id_IR         <= NOP_INST;
         if_id_valid_inst <= 1'b0;
      end else if (id_stall_flag) begin
         if_id_IR         <= if_id_IR;
      end else if (fifo_pop) begin
         if_id_IR         <= fifo_ir[rd_ptr];
         if_id_PC         <= fifo_pc[rd_ptr];
         if_id_NPC        <= fifo_pc[rd_ptr] + 32'd4;
         if_id_valid_inst <= 1'b1;
         if_fetch_count   <= if_fetch_count + 32'd1;
      end else if (bypass_load) begin
         if_id_IR         <= imem_rdata;
         if_id_PC         <= req_pc;
         if_id_NPC        <= req_pc + 32'd4;
         if_id_valid_inst <= 1'b1;
         if_fetch_count   <= if_fetch_count + 32'd1;
      end else begin
         if_id_IR         <= NOP_INST;
         if_id_valid_inst <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: queue-based reference model, randomized stall/redirect/latency,
// plus directed scenarios with literal expectations.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_stall_flag = 1'b0;
   logic        ex_take_branch = 1'b0;
   logic [31:0] ex_target_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] if_id_IR;
   logic [31:0] if_id_PC;
   logic [31:0] if_id_NPC;
   logic        if_id_valid_inst;
   logic [31:0] if_fetch_count;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk              (clk),
      .rst              (rst),
      .id_stall_flag    (id_stall_flag),
      .ex_take_branch   (ex_take_branch),
      .ex_target_pc     (ex_target_pc),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .if_id_IR         (if_id_IR),
      .if_id_PC         (if_id_PC),
      .if_id_NPC        (if_id_NPC),
      .if_id_valid_inst (if_id_valid_inst),
      .if_fetch_count   (if_fetch_count)
   );

   int n_compared = 0;
   int n_mismatch = 0;

   // Reference model: architectural view of the fetch stage
   logic [31:0] m_pc, m_req_pc, m_ir, m_pcr, m_npc, m_count;
   bit          m_busy, m_stale, m_valid;
   logic [31:0] m_qpc[$];
   logic [31:0] m_qir[$];

   // Memory model: one pending response with a randomly chosen latency
   bit          mem_pending, mem_stale_flush;
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          lat_lo, lat_hi;

   bit          obs_req, obs_valid;
   logic [31:0] obs_addr, obs_ir, obs_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic bit rv_next();
      return mem_stale_flush || (mem_pending && mem_cnt == 1);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
      n_compared++;
      if (act !== want) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_req_pc = '0; m_busy = 0; m_stale = 0;
      m_qpc.delete(); m_qir.delete();
      m_ir = NOP; m_pcr = '0; m_npc = 32'd4; m_valid = 0; m_count = '0;
   endtask

   task automatic checkOutput(input bit want_req);
      check32("imem_req", 32'(imem_req), 32'(want_req));
      check32("imem_addr", imem_addr, want_req ? m_pc : 32'h0);
      check32("if_id_IR", if_id_IR, m_ir);
      check32("if_id_PC", if_id_PC, m_pcr);
      check32("if_id_NPC", if_id_NPC, m_npc);
      check32("if_id_valid_inst", 32'(if_id_valid_inst), 32'(m_valid));
      check32("if_fetch_count", if_fetch_count, m_count);
   endtask

   // One clock cycle: drive inputs at the falling edge, check, advance the model, cross the rising edge.
   task automatic applyStimulus(input bit stall, input bit br, input logic [31:0] tgt);
      bit          rv, want_req, acc, byp;
      logic [31:0] rd, rpc;
      rv = 0; rd = '0;
      if (mem_stale_flush) begin
         rv = 1; rd = 32'hDEAD_BEEF; mem_stale_flush = 0;
      end else if (mem_pending) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            rv = 1; rd = mem_word(mem_addr); mem_pending = 0;
         end
      end
      id_stall_flag = stall; ex_take_branch = br; ex_target_pc = tgt;
      imem_rvalid = rv; imem_rdata = rd;
      #1;
      want_req = !m_busy && (m_qpc.size() < DEPTH) && !br;
      obs_req = imem_req; obs_addr = imem_addr; obs_valid = if_id_valid_inst;
      obs_ir = if_id_IR; obs_pc = if_id_PC;
      checkOutput(want_req);

      acc = m_busy && !m_stale && rv && !br;
      byp = BYP && acc && (m_qpc.size() == 0) && !stall;
      rpc = m_req_pc;
      if (m_busy && rv) begin
         m_busy = 0; m_stale = 0;
      end else if (m_busy && br) begin
         m_stale = 1;
      end
      if (br) begin
         m_valid = 0; m_ir = NOP; m_qpc.delete(); m_qir.delete();
      end else begin
         if (!stall) begin
            if (m_qpc.size() > 0) begin
               m_pcr = m_qpc.pop_front(); m_ir = m_qir.pop_front();
               m_npc = m_pcr + 32'd4; m_valid = 1; m_count = m_count + 32'd1;
            end else if (byp) begin
               m_pcr = rpc; m_ir = rd; m_npc = rpc + 32'd4; m_valid = 1; m_count = m_count + 32'd1;
            end else begin
               m_valid = 0; m_ir = NOP;
            end
         end
         if (acc && !byp) begin
            m_qpc.push_back(rpc); m_qir.push_back(rd);
         end
      end
      if (want_req) begin
         mem_pending = 1; mem_cnt = int'($urandom_range(lat_hi, lat_lo)); mem_addr = m_pc;
         m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; m_stale = 0;
      end
      if (br) m_pc = tgt & 32'hFFFF_FFFC;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      id_stall_flag = 0; ex_take_branch = 0; ex_target_pc = '0; imem_rvalid = 0; imem_rdata = '0;
      if (mem_pending) begin
         mem_pending = 0; mem_stale_flush = 1;
      end
      model_reset();
      #1;
      check32("rst_imem_req", 32'(imem_req), 32'h0);
      check32("rst_imem_addr", imem_addr, 32'h0);
      check32("rst_if_id_IR", if_id_IR, 32'h0000_0013);
      check32("rst_if_id_PC", if_id_PC, 32'h0);
      check32("rst_if_id_NPC", if_id_NPC, 32'h4);
      check32("rst_valid", 32'(if_id_valid_inst), 32'h0);
      check32("rst_fetch_count", if_fetch_count, 32'h0);
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int          first_valid;
      int          gap;
      bit          found;
      logic [31:0] vpcs[$];
      logic [31:0] vnpcs[$];
      logic [31:0] want_pcs[3];

      mem_pending = 0; mem_stale_flush = 0; mem_cnt = 0; mem_addr = '0;
      lat_lo = 1; lat_hi = 1;
      model_reset();
      @(negedge clk);
      do_reset(2);

      // Cold start with single-cycle memory
      first_valid = -1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 0, 32'h0);
         if (k == 0) begin
            check32("first_req", 32'(obs_req), 32'h1);
            check32("first_addr", obs_addr, RESET_PC);
         end
         if (obs_valid) begin
            if (first_valid < 0) first_valid = k;
            vpcs.push_back(obs_pc);
            vnpcs.push_back(if_id_NPC);
         end
      end
      check32("first_valid_cycle", 32'(first_valid), BYP ? 32'd2 : 32'd3);
      check32("cold_valid_loads", 32'(vpcs.size() >= 3), 32'h1);
      want_pcs[0] = 32'h0; want_pcs[1] = 32'h4; want_pcs[2] = 32'h8;
      for (int i = 0; i < 3 && i < vpcs.size(); i++) begin
         check32("cold_pc", vpcs[i], want_pcs[i]);
         check32("cold_npc", vnpcs[i], want_pcs[i] + 32'd4);
      end

      // ID stall fills the FIFO and stops requests; release drains it
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 0, 32'h0);
         if (k == 4) check32("stall_req_stops", 32'(obs_req), 32'h0);
      end
      for (int k = 0; k < 8; k++) applyStimulus(0, 0, 32'h0);

      // Redirect while waiting, stale response two cycles later
      lat_lo = 3; lat_hi = 3;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         applyStimulus(0, 0, 32'h0);
         found = obs_req;
      end
      check32("br_setup_req_seen", 32'(found), 32'h1);
      applyStimulus(0, 1, 32'h0000_0103);
      applyStimulus(0, 0, 32'h0);
      check32("br_bubble_valid", 32'(obs_valid), 32'h0);
      check32("br_bubble_ir", obs_ir, 32'h0000_0013);
      found = 0; gap = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         applyStimulus(0, 0, 32'h0);
         gap++;
         found = obs_req;
      end
      check32("br_next_req_seen", 32'(found), 32'h1);
      check32("br_next_addr", obs_addr, 32'h0000_0100);
      check32("br_drain_gap", 32'(gap), 32'd2);

      // Redirect coinciding with response and ID stall: no drain
      lat_lo = 2; lat_hi = 2;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         found = rv_next() && m_busy && !m_stale;
         if (!found) applyStimulus(0, 0, 32'h0);
      end
      check32("brrv_setup", 32'(found), 32'h1);
      applyStimulus(1, 1, 32'h0000_0200);
      applyStimulus(0, 0, 32'h0);
      check32("brrv_valid", 32'(obs_valid), 32'h0);
      check32("brrv_ir", obs_ir, 32'h0000_0013);
      check32("brrv_req", 32'(obs_req), 32'h1);
      check32("brrv_addr", obs_addr, 32'h0000_0200);

      // PC wrap at the top of the address space
      lat_lo = 1; lat_hi = 1;
      applyStimulus(0, 1, 32'hFFFF_FFFF);
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         applyStimulus(0, 0, 32'h0);
         found = obs_req;
      end
      check32("wrap_req1_seen", 32'(found), 32'h1);
      check32("wrap_addr1", obs_addr, 32'hFFFF_FFFC);
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         applyStimulus(0, 0, 32'h0);
         found = obs_req;
      end
      check32("wrap_req2_seen", 32'(found), 32'h1);
      check32("wrap_addr2", obs_addr, 32'h0);

      // Reset during an outstanding fetch; its late response must be ignored
      lat_lo = 3; lat_hi = 3;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         applyStimulus(0, 0, 32'h0);
         found = obs_req;
      end
      applyStimulus(0, 0, 32'h0);
      do_reset(2);
      applyStimulus(0, 0, 32'h0);
      check32("post_rst_req", 32'(obs_req), 32'h1);
      check32("post_rst_addr", obs_addr, RESET_PC);
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         applyStimulus(0, 0, 32'h0);
         found = obs_valid;
      end
      check32("post_rst_valid_seen", 32'(found), 32'h1);
      check32("post_rst_pc", obs_pc, RESET_PC);
      check32("post_rst_ir", obs_ir, mem_word(RESET_PC));

      // Randomized traffic
      lat_lo = 1; lat_hi = 4;
      for (int k = 0; k < 3000; k++) begin
         bit          st, br;
         logic [31:0] tgt;
         st = ($urandom_range(99, 0) < 25);
         br = ($urandom_range(99, 0) < 7);
         tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                          : $urandom();
         if ($urandom_range(499, 0) == 0) begin
            do_reset(1);
         end else begin
            applyStimulus(st, br, tgt);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
